// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns one command per valid/ready handshake into a
// two-phase APB transfer (SETUP, then ACCESS) and returns a one-cycle response.
// All APB-side outputs and the response channel are registered.
// Optional build macro APB_MASTER_TIMEOUT_EN: aborts an ACCESS phase that
// waits TIMEOUT_CYC cycles with pready low and reports it through rsp_err.
module apb_master_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counter value seen on the ACCESS edge that completes the last allowed wait.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_r;
`endif

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              accept_s;
    logic              done_s;
    logic              abort_s;
    logic              recover_s;

    logic              cmd_ready_r;
    logic [ADDR_W-1:0] paddr_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    // Next-state decode and one-hot event strobes for the register block.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        recover_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_SETUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nx_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    // A ready slave always wins over a coincident timeout.
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_cnt_r == TMO_LAST) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end
`endif
                else begin
                    state_nx_s = ST_ACCESS;
                end
            end
            default: begin
                // Unreachable encoding: drop the bus and return to IDLE.
                recover_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered APB outputs and the response channel.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            paddr_r     <= {ADDR_W{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= done_s | abort_s;
            if (accept_s) begin
                paddr_r     <= cmd_addr;
                pwrite_r    <= cmd_write;
                pwdata_r    <= cmd_wdata;
                psel_r      <= 1'b1;
                penable_r   <= 1'b0;
                cmd_ready_r <= 1'b0;
            end else if (state_r == ST_SETUP) begin
                penable_r <= 1'b1;
            end else if (done_s || abort_s || recover_s) begin
                psel_r      <= 1'b0;
                penable_r   <= 1'b0;
                cmd_ready_r <= 1'b1;
            end else begin
                psel_r <= psel_r;
            end
            // Response data/err hold until the next completion.
            if (done_s) begin
                rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : prdata;
                rsp_err_r   <= 1'b0;
            end else if (abort_s) begin
                rsp_rdata_r <= {DATA_W{1'b0}};
                rsp_err_r   <= 1'b1;
            end else begin
                rsp_err_r <= rsp_err_r;
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-cycle counter: cleared on entry to ACCESS, counts pready-low edges.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ST_SETUP) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACCESS) && !pready && !abort_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`endif

    assign cmd_ready = cmd_ready_r;
    assign paddr     = paddr_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule
